// File: rtl/lfsr_cipher_pkg.sv
// rtl/lfsr_cipher_pkg.sv - shared constants, FSM states and LFSR step for the LFSR cipher flow
// Contents:
//   WIDTH, TAPS, SEED_DEFAULT : keystream generator geometry and default seed
//   state_t                   : decipher frame FSM states
//   lfsr_step()               : one Fibonacci shift, feedback = XOR of tapped bits
package lfsr_cipher_pkg;

  localparam int WIDTH = 16;
  localparam logic [WIDTH-1:0] TAPS = 16'hB400;
  localparam logic [WIDTH-1:0] SEED_DEFAULT = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_keygen.sv
// rtl/lfsr_keygen.sv - Fibonacci LFSR keystream generator
// Ports:
//   clk, clr  : clock, synchronous active-high reset (reloads SEED_DEFAULT)
//   load,seed : load seed into the register (priority over step)
//   step      : advance one position
//   key_bit   : current keystream bit (MSB of the register)
module lfsr_keygen
  import lfsr_cipher_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             step,
  output logic             key_bit
);

  logic [WIDTH-1:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_lfsr <= SEED_DEFAULT;
    end else if (load) begin
      r_lfsr <= seed;
    end else if (step) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  assign key_bit = r_lfsr[WIDTH-1];

endmodule

// File: rtl/lfsr_stream_decipher.sv
// rtl/lfsr_stream_decipher.sv - serial LFSR Vernam decipher packing plaintext into bytes
// Ports:
//   clk, clr                : clock, synchronous active-high reset
//   start, seed, frame_len  : frame request, sampled only in IDLE
//   c_valid, c_bit, c_ready : ciphertext bit stream handshake
//   p_valid, p_byte, p_ready: plaintext byte handshake, first bit in p_byte[7]
//   busy, done              : frame in progress, one-cycle end-of-frame pulse
module lfsr_stream_decipher
  import lfsr_cipher_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [15:0]      frame_len,
  input  logic             c_valid,
  input  logic             c_bit,
  output logic             c_ready,
  output logic             p_valid,
  output logic [7:0]       p_byte,
  input  logic             p_ready,
  output logic             busy,
  output logic             done
);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_frame_len;
  logic [15:0] r_byte_cnt;
  logic [2:0]  r_bit_cnt;
  logic [6:0]  r_pack;       // only the 7 earlier bits are kept; the 8th goes straight out
  logic [7:0]  r_p_byte;
  logic        r_p_valid;

  logic             w_key_bit;
  logic             w_plain_bit;
  logic             w_c_ready;
  logic             w_accept;
  logic             w_last_bit;
  logic             w_byte_done;
  logic             w_last_byte;
  logic             w_start_ok;
  logic [WIDTH-1:0] w_seed_eff;

  assign w_start_ok  = (r_state == IDLE) && start;
  assign w_seed_eff  = (seed == '0) ? SEED_DEFAULT : seed;
  assign w_last_bit  = (r_bit_cnt == 3'd7);
  // Only the byte-completing bit stalls, and only while the previous byte is still held.
  assign w_c_ready   = (r_state == RUN) && !(w_last_bit && r_p_valid && !p_ready);
  assign w_accept    = c_valid && w_c_ready;
  assign w_plain_bit = c_bit ^ w_key_bit;
  assign w_byte_done = w_accept && w_last_bit;
  assign w_last_byte = ((r_byte_cnt + 16'd1) == r_frame_len);

  lfsr_keygen u_keygen (
    .clk     (clk),
    .clr     (clr),
    .load    (w_start_ok),
    .seed    (w_seed_eff),
    .step    (w_accept),
    .key_bit (w_key_bit)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next = (frame_len == 16'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_byte_done && w_last_byte) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!r_p_valid || p_ready) begin
          w_next = DONE;
        end
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_frame_len <= 16'd0;
      r_byte_cnt  <= 16'd0;
      r_bit_cnt   <= 3'd0;
      r_pack      <= 7'd0;
      r_p_byte    <= 8'd0;
      r_p_valid   <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_frame_len <= frame_len;
        r_byte_cnt  <= 16'd0;
        r_bit_cnt   <= 3'd0;
        r_pack      <= 7'd0;
      end else if (w_accept) begin
        r_pack    <= {r_pack[5:0], w_plain_bit};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (w_last_bit) begin
          r_byte_cnt <= r_byte_cnt + 16'd1;
        end
      end

      // A reload wins over a same-cycle handshake so the new byte stays valid.
      if (w_byte_done) begin
        r_p_byte  <= {r_pack, w_plain_bit};
        r_p_valid <= 1'b1;
      end else if (r_p_valid && p_ready) begin
        r_p_valid <= 1'b0;
      end
    end
  end

  assign c_ready = w_c_ready;
  assign p_valid = r_p_valid;
  assign p_byte  = r_p_byte;

endmodule

// File: doc/lfsr_stream_decipher.md
# lfsr_stream_decipher

Synthesizable Vernam decipher for the LFSR image-cypher flow. It accepts the serial ciphertext bitstream one bit per handshake and XORs each bit with a 16-bit Fibonacci LFSR keystream. It packs the recovered plaintext MSB-first into bytes and emits them on a valid/ready byte port. It is the receive/read-back end of the encryption path, so the cipher runs in hardware instead of only in simulation.

## Interface
- WIDTH, 16, LFSR width
- TAPS, 16'hB400, feedback mask; feedback = XOR of state bits 15, 13, 12, 10
- SEED_DEFAULT, 16'hACE1, seed loaded on reset and whenever a zero seed is supplied
- clk  in  1  single clock, all logic on rising edge
- clr  in  1  reset, synchronous, active-high
- start  in  1  begin frame; sampled only in IDLE
- seed  in  WIDTH  keystream seed, captured on accepted start
- frame_len  in  16  frame length in bytes, captured on accepted start
- c_valid  in  1  ciphertext bit valid
- c_bit  in  1  ciphertext bit
- c_ready  out  1  decipher can accept a bit
- p_valid  out  1  plaintext byte valid
- p_byte  out  8  plaintext byte, first received bit in bit 7
- p_ready  in  1  downstream accepts byte
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at end of frame

## Operation
- Keystream bit is lfsr[15]. Step: lfsr <= {lfsr[14:0], ^(lfsr & TAPS)}. The LFSR advances only on an accepted bit (c_valid & c_ready).
- The first 16 keystream bits equal the seed, MSB-first.
- FSM states are IDLE, RUN, DRAIN and DONE.
- IDLE: c_ready=0. On start:
  - lfsr <= (seed==0) ? SEED_DEFAULT : seed.
  - Latch frame_len; clear bit_cnt (3 b), byte_cnt (16 b) and the pack register.
  - Go to RUN, or to DONE if frame_len==0.
- RUN, on each accepted bit:
  - pack <= {pack[6:0], c_bit ^ lfsr[15]}.
  - bit_cnt++ (wraps 7→0).
- RUN, on the 8th bit (bit_cnt==7): the completed byte moves into the output register, p_valid=1, and byte_cnt++. If byte_cnt+1==frame_len, go to DRAIN.
- c_ready in RUN = !(bit_cnt==7 && p_valid && !p_ready). The stall applies only to the bit that would complete a byte while the previous byte is still unaccepted. Bits 0–6 are always accepted.
- The output register clears p_valid on p_valid & p_ready unless it reloads in the same cycle. A simultaneous handshake and reload is legal and keeps p_valid=1 with the new byte.
- DRAIN: c_ready=0. When the output register is empty (or empties this cycle), go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start outside IDLE is ignored. c_bit is ignored when !c_ready.
- clr mid-frame aborts the frame: the partial byte and any pending byte are discarded, and no done pulse is produced.

## Timing
- Reset values: state=IDLE, lfsr=SEED_DEFAULT, c_ready=0, p_valid=0, p_byte=0, busy=0, done=0, all counters 0.
- start at cycle N → c_ready=1 at N+1.
- Byte latency: the 8th bit accepted at edge N → p_valid=1 and p_byte valid after edge N (visible cycle N+1).
- Throughput is 1 bit/cycle when p_ready stays high.
- The last byte handshake at cycle M → done=1 in cycle M+1, then busy=0 in cycle M+2.
- frame_len=0: start at N → done in cycle N+1, with no byte emitted.

## Structure
- Package lfsr_cipher_pkg holds the WIDTH/TAPS/SEED_DEFAULT constants, the state enum (IDLE, RUN, DRAIN, DONE) and an lfsr_step function. The encrypt side reuses the same package.
- One sub-module, lfsr_keygen: WIDTH-bit Fibonacci LFSR with load, seed and step inputs, and a key_bit output.

## Test plan
- Reset, then start with seed=16'hACE1, frame_len=2, c_bit=0 for 16 bits, p_ready=1 → p_byte=8'hAC then 8'hE1; done one cycle after the second handshake.
- seed=16'h0000, frame_len=1, all-zero ciphertext → p_byte=8'hAC (SEED_DEFAULT used).
- Round trip: encrypt 95481 image bits with the software model (seed 16'hACE1), feed them in, padded to whole bytes → output bytes equal the original image bytes.
- Backpressure: hold p_ready=0 after the first byte → c_ready drops only on the bit that would complete the second byte, and p_byte is stable. Release p_ready → both bytes delivered in order with no loss.
- clr asserted after 5 bits of a frame → next cycle all outputs are at their reset values. A new start with seed 16'hACE1 reproduces 8'hAC for zero input.
- start with frame_len=0 → done pulse in cycle N+1, p_valid never asserted. A start pulse during RUN has no effect on byte_cnt.
